// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock level FIFO: gray/binary conversion on a
// wide word (callers size-cast to their pointer width) and level-width sizing.
package async_fifo_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   function automatic gray_word_t bin2gray(input gray_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix-XOR from the MSB down, done in log2 steps; zero upper bits are inert.
   function automatic gray_word_t gray2bin(input gray_word_t gray);
      gray_word_t bin;
      bin = gray;
      bin = bin ^ (bin >> 1);
      bin = bin ^ (bin >> 2);
      bin = bin ^ (bin >> 4);
      bin = bin ^ (bin >> 8);
      bin = bin ^ (bin >> 16);
      return bin;
   endfunction

   // A level must represent 0..DEPTH inclusive, one bit more than the address.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/async_fifo_ram.sv
// Simple dual-clock RAM: one write port, one registered read port.
module async_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  wclk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rclk_i,
   input  logic                  rrstn_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge wclk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge rclk_i or negedge rrstn_i) begin
      if (!rrstn_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer entering a new clock domain.
module gray_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [0:STAGES-1];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_level.sv
// Dual-clock FIFO with gray-coded pointer crossing, per-domain occupancy levels
// and programmable almost-full / almost-empty watermarks.
module async_fifo_level
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                    r_clk,
   input  logic                    r_rstn,
   input  logic                    w_clk,
   input  logic                    w_rstn,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   output logic [$clog2(DEPTH):0]  w_level,
   output logic                    w_almost_full,
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [$clog2(DEPTH):0]  r_level,
   output logic                    r_almost_empty
);

   localparam int PW = int'(level_width(DEPTH));
   localparam int AW = PW - 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $fatal(1, "async_fifo_level: DEPTH must be a power of 2 and >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "async_fifo_level: SYNC_STAGES must be >= 2");
   end
   if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
      $fatal(1, "async_fifo_level: AFULL_THRESH must be in 1..DEPTH");
   end
   if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
      $fatal(1, "async_fifo_level: AEMPTY_THRESH must be in 0..DEPTH-1");
   end

   // Write domain state
   logic          w_accept;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] wgray_q, wgray_d;
   logic [PW-1:0] w_level_q, w_level_d;
   logic          w_ready_q, w_ready_d;
   logic          w_afull_q, w_afull_d;
   logic [PW-1:0] rgray_w, rptr_w;

   // Read domain state
   logic          r_pop;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] rgray_q, rgray_d;
   logic [PW-1:0] r_level_q, r_level_d;
   logic          r_valid_q, r_valid_d;
   logic          r_aempty_q, r_aempty_d;
   logic [PW-1:0] wgray_r, wptr_r;

   gray_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rgray_sync (
      .clk_i  (w_clk),
      .rstn_i (w_rstn),
      .d_i    (rgray_q),
      .q_o    (rgray_w)
   );

   gray_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_wgray_sync (
      .clk_i  (r_clk),
      .rstn_i (r_rstn),
      .d_i    (wgray_q),
      .q_o    (wgray_r)
   );

   assign rptr_w = PW'(gray2bin(gray_word_t'(rgray_w)));
   assign wptr_r = PW'(gray2bin(gray_word_t'(wgray_r)));

   // The level is computed against the post-accept pointer so flags are
   // registered in step with the occupancy they describe.
   always_comb begin
      w_accept  = w_valid && w_ready_q;
      wptr_d    = wptr_q + {{AW{1'b0}}, w_accept};
      wgray_d   = PW'(bin2gray(gray_word_t'(wptr_d)));
      w_level_d = wptr_d - rptr_w;
      w_ready_d = (w_level_d != PW'(DEPTH));
      w_afull_d = (w_level_d >= PW'(AFULL_THRESH));
   end

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         wptr_q    <= '0;
         wgray_q   <= '0;
         w_level_q <= '0;
         w_ready_q <= 1'b1;
         w_afull_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         wgray_q   <= wgray_d;
         w_level_q <= w_level_d;
         w_ready_q <= w_ready_d;
         w_afull_q <= w_afull_d;
      end
   end

   always_comb begin
      r_pop      = r_valid_q && r_ready;
      rptr_d     = rptr_q + {{AW{1'b0}}, r_pop};
      rgray_d    = PW'(bin2gray(gray_word_t'(rptr_d)));
      r_level_d  = wptr_r - rptr_d;
      r_valid_d  = (r_level_d != '0);
      r_aempty_d = (r_level_d <= PW'(AEMPTY_THRESH));
   end

   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         rptr_q     <= '0;
         rgray_q    <= '0;
         r_level_q  <= '0;
         r_valid_q  <= 1'b0;
         r_aempty_q <= 1'b1;
      end else begin
         rptr_q     <= rptr_d;
         rgray_q    <= rgray_d;
         r_level_q  <= r_level_d;
         r_valid_q  <= r_valid_d;
         r_aempty_q <= r_aempty_d;
      end
   end

   // Reading at the next pointer puts the new head on r_data together with r_valid.
   async_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .wclk_i  (w_clk),
      .we_i    (w_accept),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (w_data),
      .rclk_i  (r_clk),
      .rrstn_i (r_rstn),
      .raddr_i (rptr_d[AW-1:0]),
      .rdata_o (r_data)
   );

   assign w_ready        = w_ready_q;
   assign w_level        = w_level_q;
   assign w_almost_full  = w_afull_q;
   assign r_valid        = r_valid_q;
   assign r_level        = r_level_q;
   assign r_almost_empty = r_aempty_q;

endmodule

// File: tb/tb_async_fifo_level.sv
// Bench for async_fifo_level: fill/drain vector tables, latency, stall, wrap,
// randomized dual-ratio traffic and mid-burst reset, against a queue model.
module tb_async_fifo_level;

   localparam int DW     = 8;
   localparam int DEPTH  = 8;
   localparam int SYNC   = 2;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 1;
   localparam int LW     = 4;

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      int            exp_level;
      logic          exp_ready;
      logic          exp_afull;
   } wvec_t;

   typedef struct {
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      int            exp_level;
      logic          exp_aempty;
   } rvec_t;

   // ---------------- clock / reset ----------------
   logic w_clk = 1'b0;
   logic r_clk = 1'b0;
   logic w_rstn = 1'b0;
   logic r_rstn = 1'b0;
   int   w_half = 5;
   int   r_half = 10;

   initial forever #(w_half) w_clk = ~w_clk;
   initial begin
      #2;
      forever #(r_half) r_clk = ~r_clk;
   end

   logic          w_valid = 1'b0;
   logic [DW-1:0] w_data = '0;
   logic          r_ready = 1'b0;
   logic          w_ready, w_almost_full, r_valid, r_almost_empty;
   logic [DW-1:0] r_data;
   logic [LW-1:0] w_level, r_level;

   async_fifo_level #(
      .DATA_WIDTH    (DW),
      .DEPTH         (DEPTH),
      .SYNC_STAGES   (SYNC),
      .AFULL_THRESH  (AFULL),
      .AEMPTY_THRESH (AEMPTY)
   ) dut (
      .r_clk          (r_clk),
      .r_rstn         (r_rstn),
      .w_clk          (w_clk),
      .w_rstn         (w_rstn),
      .w_valid        (w_valid),
      .w_ready        (w_ready),
      .w_data         (w_data),
      .w_level        (w_level),
      .w_almost_full  (w_almost_full),
      .r_valid        (r_valid),
      .r_ready        (r_ready),
      .r_data         (r_data),
      .r_level        (r_level),
      .r_almost_empty (r_almost_empty)
   );

   // ---------------- scoreboard / model ----------------
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   int            rd_idx = 0;
   bit            inv_on = 1'b0;
   int            occ_w = 0;
   bit            wrap_mon = 1'b0;
   int            wrap_full_cnt = 0;
   wvec_t         wv [9];
   rvec_t         rv [9];
   logic [DW-1:0] head;
   int            n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge w_clk) begin
      if (w_rstn && w_valid && w_ready) exp_q.push_back(w_data);
   end

   always @(posedge r_clk) begin
      if (!r_rstn) begin
         rd_idx = exp_q.size();
      end else if (r_valid && r_ready) begin
         checks++;
         if (rd_idx >= exp_q.size()) begin
            errors++;
            $display("FAIL sb_pop_empty data=%0h required=none t=%0t", r_data, $time);
         end else begin
            if (r_data !== exp_q[rd_idx]) begin
               errors++;
               $display("FAIL sb_data actual=%0h required=%0h t=%0t", r_data, exp_q[rd_idx], $time);
            end
            rd_idx++;
         end
      end
   end

   // w_level >= true occupancy >= r_level, neither above DEPTH
   always @(negedge w_clk) begin
      if (inv_on) begin
         occ_w = exp_q.size() - rd_idx;
         checks++;
         if (!((int'(w_level) >= occ_w) && (occ_w >= int'(r_level)) &&
               (int'(w_level) <= DEPTH) && (int'(r_level) <= DEPTH))) begin
            errors++;
            $display("FAIL level_bounds w_level=%0d occ=%0d r_level=%0d required w>=occ>=r,<=%0d t=%0t",
                     w_level, occ_w, r_level, DEPTH, $time);
         end
      end
   end

   always @(negedge w_clk) begin
      if (wrap_mon && !w_ready) wrap_full_cnt++;
   end

   always @(posedge w_clk) begin
      assert (w_rstn == r_rstn) else begin
         errors++;
         $display("FAIL reset_overlap w_rstn=%0b r_rstn=%0b required equal t=%0t", w_rstn, r_rstn, $time);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_word(input logic [DW-1:0] d);
      int k;
      k = 0;
      @(negedge w_clk);
      while (!w_ready && k < 200) begin
         @(negedge w_clk);
         k++;
      end
      checks++;
      if (!w_ready) begin
         errors++;
         $display("FAIL write_word_timeout w_ready=%0b required=1", w_ready);
      end else begin
         w_valid = 1'b1;
         w_data  = d;
         @(negedge w_clk);
         w_valid = 1'b0;
      end
   endtask

   task automatic stream_write(input int nwords, input int pct);
      int sent;
      int guard;
      sent  = 0;
      guard = 0;
      while (sent < nwords && guard < 60000) begin
         @(negedge w_clk);
         w_valid = ($urandom_range(99) < pct);
         w_data  = DW'($urandom_range(255));
         @(posedge w_clk);
         if (w_valid && w_ready) sent++;
         guard++;
      end
      @(negedge w_clk);
      w_valid = 1'b0;
      check("stream_write_count", 32'(sent), 32'(nwords));
   endtask

   task automatic stream_read(input int nwords, input int pct);
      int target;
      int guard;
      target = rd_idx + nwords;
      guard  = 0;
      while (rd_idx < target && guard < 60000) begin
         @(negedge r_clk);
         r_ready = ($urandom_range(99) < pct);
         @(posedge r_clk);
         guard++;
      end
      @(negedge r_clk);
      r_ready = 1'b0;
      check("stream_read_count", 32'(rd_idx), 32'(target));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_w_ready"}, 32'(w_ready), 32'(1));
      check({tag, "_w_level"}, 32'(w_level), 32'(0));
      check({tag, "_w_afull"}, 32'(w_almost_full), 32'(0));
      check({tag, "_r_valid"}, 32'(r_valid), 32'(0));
      check({tag, "_r_level"}, 32'(r_level), 32'(0));
      check({tag, "_r_aempty"}, 32'(r_almost_empty), 32'(1));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #(64'd6000000);
      errors++;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 8; i++) begin
         wv[i] = '{valid: 1'b1, data: DW'(i), exp_level: i + 1,
                   exp_ready: ((i + 1) != DEPTH), exp_afull: ((i + 1) >= AFULL)};
      end
      wv[8] = '{valid: 1'b1, data: 8'hFF, exp_level: DEPTH, exp_ready: 1'b0, exp_afull: 1'b1};
      for (int i = 0; i < 9; i++) begin
         rv[i] = '{exp_valid: (i < DEPTH), exp_data: DW'(i), exp_level: DEPTH - i,
                   exp_aempty: ((DEPTH - i) <= AEMPTY)};
      end

      repeat (3) @(negedge r_clk);
      check_reset_values("por");
      @(negedge w_clk);
      w_rstn = 1'b1;
      r_rstn = 1'b1;
      repeat (5) @(negedge r_clk);
      inv_on = 1'b1;

      // Fill with reader stalled
      for (int i = 0; i < 9; i++) begin
         @(negedge w_clk);
         w_valid = wv[i].valid;
         w_data  = wv[i].data;
         @(posedge w_clk);
         #1;
         check($sformatf("fill_level_%0d", i), 32'(w_level), 32'(wv[i].exp_level));
         check($sformatf("fill_ready_%0d", i), 32'(w_ready), 32'(wv[i].exp_ready));
         check($sformatf("fill_afull_%0d", i), 32'(w_almost_full), 32'(wv[i].exp_afull));
         if (i == DEPTH - 1) begin
            n = 0;
            while (r_level != LW'(DEPTH) && n < 20) begin
               @(posedge r_clk);
               #1;
               n++;
            end
            check("fill_r_level", 32'(r_level), 32'(DEPTH));
            checks++;
            if (n > SYNC + 2) begin
               errors++;
               $display("FAIL fill_r_latency edges=%0d required<=%0d", n, SYNC + 2);
            end
         end
      end
      @(negedge w_clk);
      w_valid = 1'b0;

      // Drain in order
      for (int i = 0; i < 9; i++) begin
         @(negedge r_clk);
         check($sformatf("drain_valid_%0d", i), 32'(r_valid), 32'(rv[i].exp_valid));
         check($sformatf("drain_level_%0d", i), 32'(r_level), 32'(rv[i].exp_level));
         check($sformatf("drain_aempty_%0d", i), 32'(r_almost_empty), 32'(rv[i].exp_aempty));
         if (rv[i].exp_valid) check($sformatf("drain_data_%0d", i), 32'(r_data), 32'(rv[i].exp_data));
         r_ready = rv[i].exp_valid;
      end
      n = 0;
      while (w_level != '0 && n < 20) begin
         @(negedge w_clk);
         n++;
      end
      check("drain_w_level", 32'(w_level), 32'(0));
      check("drain_w_ready", 32'(w_ready), 32'(1));

      // Stall: head and level hold while r_ready is low
      stream_write(3, 100);
      repeat (10) @(negedge r_clk);
      head = exp_q[rd_idx];
      for (int i = 0; i < 20; i++) begin
         @(negedge r_clk);
         check("stall_valid", 32'(r_valid), 32'(1));
         check("stall_data", 32'(r_data), 32'(head));
         check("stall_level", 32'(r_level), 32'(3));
      end
      stream_read(3, 100);

      // Wrap: 40 words in bursts of 5, reader always ready
      w_half = 5;
      r_half = 5;
      wrap_mon = 1'b1;
      fork
         begin
            for (int b = 0; b < 8; b++) begin
               stream_write(5, 100);
               repeat (12) @(negedge w_clk);
            end
         end
         stream_read(40, 100);
      join
      wrap_mon = 1'b0;
      check("wrap_no_false_full", 32'(wrap_full_cnt), 32'(0));
      repeat (10) @(negedge w_clk);
      check("wrap_r_valid", 32'(r_valid), 32'(0));
      check("wrap_w_level", 32'(w_level), 32'(0));

      // Random traffic, write clock 3x faster then 3x slower
      w_half = 5;
      r_half = 15;
      fork
         stream_write(5000, 80);
         stream_read(5000, 80);
      join
      w_half = 15;
      r_half = 5;
      fork
         stream_write(5000, 80);
         stream_read(5000, 80);
      join
      repeat (10) @(negedge w_clk);
      check("random_drained_w_level", 32'(w_level), 32'(0));

      // Reset both domains with 5 words queued
      w_half = 5;
      r_half = 10;
      r_ready = 1'b0;
      stream_write(5, 100);
      repeat (6) @(negedge r_clk);
      check("pre_reset_r_level", 32'(r_level), 32'(5));
      @(negedge w_clk);
      #1;
      inv_on = 1'b0;
      w_rstn = 1'b0;
      r_rstn = 1'b0;
      #1;
      check_reset_values("mid_reset");
      repeat (5) @(negedge r_clk);
      @(negedge w_clk);
      w_rstn = 1'b1;
      r_rstn = 1'b1;
      repeat (5) @(negedge r_clk);
      inv_on = 1'b1;
      check("post_reset_r_valid", 32'(r_valid), 32'(0));
      write_word(8'hA5);
      n = 0;
      while (!r_valid && n < 20) begin
         @(negedge r_clk);
         n++;
      end
      check("a5_valid", 32'(r_valid), 32'(1));
      check("a5_data", 32'(r_data), 32'(8'hA5));
      check("a5_level", 32'(r_level), 32'(1));
      r_ready = 1'b1;
      @(negedge r_clk);
      r_ready = 1'b0;
      repeat (5) @(negedge r_clk);
      check("a5_only_valid", 32'(r_valid), 32'(0));
      check("a5_only_level", 32'(r_level), 32'(0));
      check("sb_all_read", 32'(rd_idx), 32'(exp_q.size()));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
